// File: rtl/nes_controller_reader_if.sv
// Signal bundle between the NES gamepad pins, the controller reader and the
// game logic.
//   nes_in      : controller serial data, active-low, asynchronous
//   nes_latch   : latch strobe to the controller, active-high
//   nes_pulse   : clock strobe to the controller, active-high
//   buttons     : frame-stable button state, 1 = pressed
//                 [7] A [6] B [5] Select [4] Start [3] Up [2] Down [1] Left [0] Right
//   pressed     : one-cycle strobe per button that went 0->1 this frame
//   frame_valid : one-cycle strobe when buttons updates
// master = the reader, slave = the controller/game side.
interface nes_controller_reader_if;
  logic       nes_in;
  logic       nes_latch;
  logic       nes_pulse;
  logic [7:0] buttons;
  logic [7:0] pressed;
  logic       frame_valid;

  modport master (
    input  nes_in,
    output nes_latch,
    output nes_pulse,
    output buttons,
    output pressed,
    output frame_valid
  );

  modport slave (
    output nes_in,
    input  nes_latch,
    input  nes_pulse,
    input  buttons,
    input  pressed,
    input  frame_valid
  );
endinterface

// File: rtl/nes_controller_reader.sv
// Polls a standard NES gamepad once per POLL_CYCLES and publishes the
// 8-button state once per frame.
// Ports:
//   clk        : system clock
//   hard_reset : asynchronous, active-high reset
//   bus        : nes_controller_reader_if master modport (pins + frame outputs)
// Frame: LATCH for LATCH_CYCLES, then 7 x (PULSE_HI, PULSE_LO) of
// HALF_BIT_CYCLES each, then one DONE cycle. Bits are sampled on the last
// cycle of LATCH / PULSE_HI through a two-flop synchroniser, MSB first.
module nes_controller_reader #(
  parameter int unsigned POLL_CYCLES     = 833333,
  parameter int unsigned LATCH_CYCLES    = 600,
  parameter int unsigned HALF_BIT_CYCLES = 300
) (
  input  logic                    clk,
  input  logic                    hard_reset,
  nes_controller_reader_if.master bus
);

  localparam int unsigned POLL_W  = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int unsigned PH_MAX  = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
  localparam int unsigned PHASE_W = $clog2(PH_MAX);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LATCH    = 3'd1;
  localparam logic [2:0] S_PULSE_HI = 3'd2;
  localparam logic [2:0] S_PULSE_LO = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic               sync1;
  logic               din_s;
  logic [POLL_W-1:0]  poll_cnt;
  logic               start;
  logic [2:0]         state;
  logic [2:0]         state_n;
  logic [PHASE_W-1:0] phase;
  logic [3:0]         bit_cnt;
  logic [7:0]         shift_reg;
  logic               latch_last;
  logic               half_last;
  logic               sample;

  // Synchroniser; idles at 1 (released).
  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      sync1 <= 1'b1;
      din_s <= 1'b1;
    end else begin
      sync1 <= bus.nes_in;
      din_s <= sync1;
    end
  end

  assign start = (poll_cnt == POLL_W'(POLL_CYCLES - 1));

  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      poll_cnt <= '0;
    end else if (start) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  assign latch_last = (phase == PHASE_W'(LATCH_CYCLES - 1));
  assign half_last  = (phase == PHASE_W'(HALF_BIT_CYCLES - 1));
  assign sample     = ((state == S_LATCH) && latch_last) ||
                      ((state == S_PULSE_HI) && half_last);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (start)      state_n = S_LATCH;
      S_LATCH:    if (latch_last) state_n = S_PULSE_HI;
      S_PULSE_HI: if (half_last)  state_n = S_PULSE_LO;
      S_PULSE_LO: if (half_last)  state_n = (bit_cnt < 4'd8) ? S_PULSE_HI : S_DONE;
      S_DONE:                     state_n = S_IDLE;
      default:                    state_n = S_IDLE;
    endcase
  end

  // Strobes and frame outputs are registered from the next-state decode so
  // they change on the same edge as the state they belong to, glitch-free.
  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      state           <= S_IDLE;
      phase           <= '0;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      bus.nes_latch   <= 1'b0;
      bus.nes_pulse   <= 1'b0;
      bus.buttons     <= '0;
      bus.pressed     <= '0;
      bus.frame_valid <= 1'b0;
    end else begin
      state <= state_n;
      if ((state_n != state) || (state == S_IDLE)) begin
        phase <= '0;
      end else begin
        phase <= phase + 1'b1;
      end

      if (sample) begin
        shift_reg <= {shift_reg[6:0], ~din_s};
        bit_cnt   <= (state == S_LATCH) ? 4'd1 : bit_cnt + 4'd1;
      end

      bus.nes_latch   <= (state_n == S_LATCH);
      bus.nes_pulse   <= (state_n == S_PULSE_HI);
      bus.frame_valid <= (state_n == S_DONE);
      if (state_n == S_DONE) begin
        bus.buttons <= shift_reg;
        bus.pressed <= shift_reg & ~bus.buttons;
      end else begin
        bus.pressed <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nes_controller_reader.sv
// Directed bench for nes_controller_reader with a behavioural NES pad model.
module tb_nes_controller_reader;
  localparam int unsigned P = 200;
  localparam int unsigned L = 6;
  localparam int unsigned H = 3;
  localparam int FV_REL = 48;

  logic clk = 1'b0;
  logic hard_reset = 1'b0;
  always #5 clk = ~clk;

  nes_controller_reader_if bus ();

  nes_controller_reader #(
    .POLL_CYCLES(P),
    .LATCH_CYCLES(L),
    .HALF_BIT_CYCLES(H)
  ) dut (
    .clk(clk),
    .hard_reset(hard_reset),
    .bus(bus.master)
  );

  // Pad model: index clears on latch, advances on each pulse rising edge.
  logic [7:0] pat = 8'h00;
  int idx = 0;
  always @(posedge bus.nes_pulse or posedge bus.nes_latch) begin
    if (bus.nes_latch) idx = 0;
    else idx = idx + 1;
  end
  assign bus.nes_in = (idx < 8) ? ~pat[7-idx] : 1'b1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int overlap = 0;
  always @(negedge clk) if (bus.nes_latch && bus.nes_pulse) overlap++;

  int n_cmp = 0;
  int n_bad = 0;
  int last_latch = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_latch(output int n, output int fv_seen);
    n = 0;
    fv_seen = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (bus.frame_valid) fv_seen++;
      if (bus.nes_latch) break;
    end
  endtask

  // Called on the first negedge with nes_latch high (latch-relative cycle 0).
  task automatic run_frame(output int lat_len, output int pul_rise, output int pul_hi,
                           output int fv_rel, output int fv_cnt,
                           output logic [7:0] b, output logic [7:0] p,
                           output logic [7:0] p_after, output logic fv_after);
    logic prev_pulse;
    prev_pulse = 1'b0;
    lat_len = 1;
    pul_rise = 0;
    pul_hi = 0;
    fv_rel = -1;
    fv_cnt = 0;
    b = 8'hxx;
    p = 8'hxx;
    p_after = 8'hxx;
    fv_after = 1'bx;
    for (int r = 1; r < 60; r++) begin
      @(negedge clk);
      if (bus.nes_latch) lat_len++;
      if (bus.nes_pulse) begin
        pul_hi++;
        if (!prev_pulse) pul_rise++;
      end
      prev_pulse = bus.nes_pulse;
      if (bus.frame_valid) begin
        fv_cnt++;
        fv_rel = r;
        b = bus.buttons;
        p = bus.pressed;
      end
      if (r == FV_REL + 1) begin
        p_after = bus.pressed;
        fv_after = bus.frame_valid;
      end
    end
  endtask

  // after_reset: the latch is expected P cycles after a reset release that
  // happened at the preceding negedge; otherwise P cycles after the last latch.
  task automatic frame(input string tag, input logic [7:0] pt, input logic [7:0] eb,
                       input logic [7:0] ep, input bit after_reset);
    int n, fv_seen, lat_len, pul_rise, pul_hi, fv_rel, fv_cnt;
    logic [7:0] b, p, p_after;
    logic fv_after;
    pat = pt;
    wait_latch(n, fv_seen);
    if (after_reset) chk({tag, ".latch_after_release"}, n, P);
    else chk({tag, ".latch_period"}, cyc - last_latch, P);
    last_latch = cyc;
    chk({tag, ".no_fv_before_latch"}, fv_seen, 0);
    run_frame(lat_len, pul_rise, pul_hi, fv_rel, fv_cnt, b, p, p_after, fv_after);
    chk({tag, ".latch_len"}, lat_len, L);
    chk({tag, ".pulse_count"}, pul_rise, 7);
    chk({tag, ".pulse_high_cycles"}, pul_hi, 7 * H);
    chk({tag, ".fv_cycle"}, fv_rel, FV_REL);
    chk({tag, ".fv_count"}, fv_cnt, 1);
    chk({tag, ".buttons"}, {24'h0, b}, {24'h0, eb});
    chk({tag, ".pressed"}, {24'h0, p}, {24'h0, ep});
    chk({tag, ".pressed_cleared"}, {24'h0, p_after}, 32'h0);
    chk({tag, ".fv_cleared"}, {31'h0, fv_after}, 32'h0);
  endtask

  initial begin
    int n, fv_seen, rises;
    logic prev_pulse;

    #2 hard_reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset.nes_latch", {31'h0, bus.nes_latch}, 32'h0);
    chk("reset.nes_pulse", {31'h0, bus.nes_pulse}, 32'h0);
    chk("reset.buttons", {24'h0, bus.buttons}, 32'h0);
    chk("reset.pressed", {24'h0, bus.pressed}, 32'h0);
    chk("reset.frame_valid", {31'h0, bus.frame_valid}, 32'h0);
    hard_reset = 1'b0;

    frame("idle", 8'h00, 8'h00, 8'h00, 1'b1);
    frame("a_start_1", 8'h90, 8'h90, 8'h90, 1'b0);
    frame("a_start_2", 8'h90, 8'h90, 8'h00, 1'b0);
    frame("start_left", 8'h12, 8'h12, 8'h02, 1'b0);
    frame("right_only", 8'h01, 8'h01, 8'h01, 1'b0);
    frame("a_only", 8'h80, 8'h80, 8'h80, 1'b0);

    // Abort a frame during the 4th clock pulse.
    pat = 8'hFF;
    wait_latch(n, fv_seen);
    chk("abort.latch_period", cyc - last_latch, P);
    rises = 0;
    prev_pulse = 1'b0;
    for (int r = 0; r < 60; r++) begin
      @(negedge clk);
      if (bus.nes_pulse && !prev_pulse) rises++;
      prev_pulse = bus.nes_pulse;
      if (rises == 4) break;
    end
    chk("abort.reached_pulse4", rises, 4);
    hard_reset = 1'b1;
    #1;
    chk("abort.nes_pulse", {31'h0, bus.nes_pulse}, 32'h0);
    chk("abort.nes_latch", {31'h0, bus.nes_latch}, 32'h0);
    chk("abort.buttons", {24'h0, bus.buttons}, 32'h0);
    chk("abort.frame_valid", {31'h0, bus.frame_valid}, 32'h0);
    repeat (3) @(negedge clk);
    hard_reset = 1'b0;
    frame("after_abort", 8'hFF, 8'hFF, 8'hFF, 1'b1);

    chk("latch_pulse_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nes_controller_reader.md
# nes_controller_reader

Polls a standard NES gamepad over its three-wire serial protocol and presents a debounced-by-frame, active-high 8-button state to the game logic. It sits directly downstream of the board-level `nes_in` pin, which carries the controller's serial data, and upstream of the Tetris game FSM. It generates the controller's `latch` and `pulse` strobes, resynchronises the returned data and shifts in one frame per poll period. Per frame it publishes the button vector, a one-cycle frame-valid strobe and one-cycle newly-pressed strobes.

## Interface
Parameters:
- `POLL_CYCLES`, 833333: clock cycles between frame starts (60 Hz at 50 MHz). Must exceed `LATCH_CYCLES + 14*HALF_BIT_CYCLES + 4`.
- `LATCH_CYCLES`, 600: width of the latch pulse in cycles (12 µs). Must be ≥ 3.
- `HALF_BIT_CYCLES`, 300: high time and low time of each clock pulse (6 µs). Must be ≥ 3.

Ports:
- `clk`, input, 1: system clock (50 MHz).
- `hard_reset`, input, 1: asynchronous, active-high reset.
- `nes_in`, input, 1: controller serial data, active-low (0 = pressed), asynchronous to `clk`.
- `nes_latch`, output, 1: controller latch strobe, active-high.
- `nes_pulse`, output, 1: controller clock strobe, active-high.
- `buttons`, output, 8: current state, 1 = pressed. Bit mapping: [7] A, [6] B, [5] Select, [4] Start, [3] Up, [2] Down, [1] Left, [0] Right.
- `pressed`, output, 8: one-cycle strobe, set for each button that went 0→1 this frame.
- `frame_valid`, output, 1: one-cycle strobe when `buttons` updates.

## Operation
- Synchroniser:
  - `nes_in` passes through two flops; the second flop's output is `din_s`.
  - `din_s` resets to 1 (released).
- Poll counter:
  - Free-running, 0..`POLL_CYCLES-1`, resets to 0.
  - When it equals `POLL_CYCLES-1` it wraps to 0 and raises `start` for that cycle.
- FSM states: IDLE, LATCH, PULSE_HI, PULSE_LO, DONE. Reset state is IDLE.
- IDLE:
  - `nes_latch`=0, `nes_pulse`=0.
  - `start` → LATCH. `start` is ignored in every other state; it cannot occur there given the parameter constraint.
- LATCH:
  - `nes_latch`=1 for exactly `LATCH_CYCLES` cycles.
  - On the last cycle, shift `~din_s` into the shift register (bit A); bit counter = 1.
  - Then go to PULSE_HI.
- PULSE_HI:
  - `nes_pulse`=1 for `HALF_BIT_CYCLES` cycles.
  - On the last cycle, shift in `~din_s` and increment the bit counter.
  - Then go to PULSE_LO.
- PULSE_LO:
  - `nes_pulse`=0 for `HALF_BIT_CYCLES` cycles.
  - Then go to PULSE_HI if the bit counter is below 8, otherwise to DONE.
- DONE (one cycle):
  - `buttons` ← shift register.
  - `pressed` ← shift register & ~old `buttons`.
  - `frame_valid`=1.
  - Then go to IDLE.
- Shift register: MSB-first. The first bit captured (A) ends in [7]; the last (Right) ends in [0].
- A single phase counter serves LATCH, PULSE_HI and PULSE_LO; it clears on every state entry.

## Timing
- Reset values:
  - `nes_latch`=0, `nes_pulse`=0, `buttons`=0, `pressed`=0, `frame_valid`=0.
  - Shift register, bit counter, phase counter and poll counter all 0; state IDLE.
- Reset asserted mid-frame: every output drops to 0 asynchronously; the aborted frame is discarded with no `frame_valid`.
- First frame: `nes_latch` rises on clock edge `POLL_CYCLES` after reset release, then repeats every `POLL_CYCLES` cycles.
- Frame length from `nes_latch` rise:
  - `LATCH_CYCLES + 14*HALF_BIT_CYCLES` cycles of LATCH/PULSE, then 1 DONE cycle.
  - `frame_valid` is high in cycle `LATCH_CYCLES + 14*HALF_BIT_CYCLES` (counting from 0).
- Registered outputs: `buttons`, `pressed` and `frame_valid` change on the same edge and come straight from flops.
- `pressed` and `frame_valid` are high for exactly one cycle per frame. At all other times they are 0.
- A button held across frames: `pressed` bit is 0 after the first frame.
- A button released: `buttons` bit clears; no strobe.
- `nes_latch` and `nes_pulse` are never high at the same time; they are glitch-free registered outputs.
- Sampling point: each bit is sampled on the last cycle of its phase. That point is at least `HALF_BIT_CYCLES-1` cycles after the data edge, which covers the 2-cycle synchroniser delay.

## Test plan
Simulation parameters: `POLL_CYCLES`=200, `LATCH_CYCLES`=6, `HALF_BIT_CYCLES`=3. Bench controller model: index resets to 0 while `nes_latch`=1 and advances on each `nes_pulse` rising edge; `nes_in` = ~pattern[7-index].
- Reset, then idle with `nes_in`=1 → `nes_latch` rises at cycle 200 and stays high 6 cycles. Seven `nes_pulse` highs of 3 cycles each, separated by 3 low cycles. `frame_valid` at latch-relative cycle 48. `buttons`=0x00, `pressed`=0x00.
- Model pattern 0x90 (A+Start) → after frame 1, `buttons`=0x90, `pressed`=0x90. Same pattern in frame 2 → `buttons`=0x90, `pressed`=0x00.
- Pattern 0x90, then 0x12 (Start+Left) → frame 2 gives `buttons`=0x12, `pressed`=0x02.
- Pattern 0x01 (Right only, last bit) → `buttons`=0x01. Pattern 0x80 (A only, sampled in LATCH) → `buttons`=0x80.
- Assert `hard_reset` during the 4th pulse with pattern 0xFF → `nes_pulse`=0 and `buttons`=0 immediately, with no `frame_valid`. Next `nes_latch` comes 200 cycles after release; that frame yields `buttons`=0xFF, `pressed`=0xFF.
- Across 5 consecutive frames → `nes_latch` rises exactly 200 cycles apart; `nes_latch` and `nes_pulse` are never both high.
